// File: rtl/excess3_to_bcd_seq_if.sv
// Handshake bundle for the Excess-3 to BCD decoder: input word channel and result channel.
interface excess3_to_bcd_seq_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err_mask;
  logic                  out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_mask, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_mask, out_err
  );
endinterface

// File: rtl/excess3_to_bcd_seq.sv
// Sequential Excess-3 to BCD decoder: one digit per clock, LSB nibble first,
// with a per-digit illegal-code mask on the result.
module excess3_to_bcd_seq #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  excess3_to_bcd_seq_if.slave  bus,
  output logic                 busy
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [W-1:0]       result_q, result_d;
  logic [DIGITS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4:0]         dec;

  // Returns {illegal, bcd}; illegal codes decode to 4'hF.
  function automatic logic [4:0] decode_digit(input logic [3:0] e);
    if (e >= 4'h3 && e <= 4'hC) return {1'b0, e - 4'h3};
    else                        return {1'b1, 4'hF};
  endfunction

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    result_d = result_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    dec      = decode_digit(shift_q[3:0]);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d  = bus.in_data;
          result_d = '0;
          mask_d   = '0;
          idx_d    = '0;
          state_d  = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[4*i +: 4] = dec[3:0];
            mask_d[i]          = dec[4];
          end
        end
        shift_d = shift_q >> 4;
        // Index holds at the last digit instead of wrapping.
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      result_q <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign busy             = (state_q != IDLE);
  assign bus.out_data     = result_q;
  assign bus.out_err_mask = mask_q;
  assign bus.out_err      = |mask_q;
endmodule
